// File: rtl/game_ctrl.sv
// Frogger game-state sequencer: lives, score, level, per-life countdown and frog respawn control.
// Define GAME_CTRL_TIMER_EN to build the per-life countdown and timeout death.
module game_ctrl #(
    parameter int LIVES_INIT = 3,
    parameter int TIME_LIMIT = 30,
    parameter int CLK_HZ     = 50_000_000,
    parameter int DEATH_HOLD = 25_000_000,
    parameter int MAX_LEVEL  = 9
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [9:0]  frogY,
    input  logic        collide,
    input  logic [4:0]  home,
    input  logic        allHome,
    output logic        frog_respawn,
    output logic        gameOver,
    output logic [3:0]  speed,
    output logic [2:0]  lives,
    output logic [13:0] score,
    output logic [5:0]  time_left,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        DYING   = 3'd2,
        RESPAWN = 3'd3,
        OVER    = 3'd4
    } state_t;

    localparam int DW = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;
    localparam logic [9:0] Y_START = 10'd428;

    state_t        st, st_n;
    logic [9:0]    min_y;
    logic [4:0]    home_q;
    logic [DW-1:0] dcnt;
    logic [2:0]    lives_n;
    logic [3:0]    speed_n;
    logic [13:0]   score_n;
    logic [14:0]   add, sum;
    logic          fwd, hit, ah, timeout;

`ifdef GAME_CTRL_TIMER_EN
    localparam int SW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    logic [SW-1:0] sec_cnt;
    logic          sec_wrap;
    assign sec_wrap = (st == PLAY) && (sec_cnt == SW'(CLK_HZ - 1));
    assign timeout  = sec_wrap && (time_left == 6'd1);
`else
    assign timeout  = 1'b0;
`endif

    assign state = st;

    always_comb begin
        fwd = (st == PLAY) && (frogY < min_y);
        hit = (st == PLAY) && (|(home & ~home_q));
        ah  = allHome && (st == PLAY || st == DYING || st == RESPAWN);
        // all same-cycle awards are summed before the 9999 clamp
        add = (fwd ? 15'd10 : 15'd0) + (hit ? 15'd50 : 15'd0) + (ah ? 15'd1000 : 15'd0);
        sum = {1'b0, score} + add;
        score_n = (sum > 15'd9999) ? 14'd9999 : sum[13:0];
        speed_n = (ah && speed < 4'(MAX_LEVEL)) ? speed + 4'd1 : speed;
        lives_n = lives;
        st_n    = st;
        case (st)
            IDLE: if (start) begin
                st_n    = RESPAWN;
                score_n = 14'd0;
                lives_n = 3'(LIVES_INIT);
                speed_n = 4'd0;
            end
            RESPAWN: st_n = PLAY;
            PLAY: begin
                // home entry beats a simultaneous collision or timeout
                if (hit) st_n = RESPAWN;
                else if (collide || timeout) begin
                    st_n    = DYING;
                    lives_n = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
                end
            end
            DYING: if (dcnt == DW'(DEATH_HOLD - 1))
                st_n = (lives == 3'd0) ? OVER : RESPAWN;
            OVER: if (start) st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            st           <= IDLE;
            frog_respawn <= 1'b1;
            gameOver     <= 1'b0;
            speed        <= 4'd0;
            lives        <= 3'(LIVES_INIT);
            score        <= 14'd0;
            min_y        <= Y_START;
            home_q       <= 5'd0;
            dcnt         <= '0;
        end else begin
            st           <= st_n;
            frog_respawn <= (st_n != PLAY);
            gameOver     <= (st_n == OVER);
            speed        <= speed_n;
            lives        <= lives_n;
            score        <= score_n;
            home_q       <= home;
            dcnt         <= (st == DYING) ? dcnt + DW'(1) : '0;
            if (st == RESPAWN) min_y <= Y_START;
            else if (fwd)      min_y <= frogY;
        end
    end

`ifdef GAME_CTRL_TIMER_EN
    always_ff @(posedge clk) begin
        if (Reset || st == RESPAWN) begin
            sec_cnt   <= '0;
            time_left <= 6'(TIME_LIMIT);
        end else if (st == PLAY) begin
            if (sec_wrap) begin
                sec_cnt <= '0;
                if (time_left != 6'd0) time_left <= time_left - 6'd1;
            end else begin
                sec_cnt <= sec_cnt + SW'(1);
            end
        end
    end
`else
    always_ff @(posedge clk) time_left <= 6'(TIME_LIMIT);
`endif
endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game-state sequencer for Frogger, directly downstream of the frog movement block and of the hazard collision detector. It consumes frog position, collision, home-occupancy and all-home signals. It produces the frog's respawn reset, the `gameOver` clear, the difficulty `speed`, and lives, score and countdown for the HUD renderer. All outputs are registered.

## Interface

**Parameters**
- `LIVES_INIT`, 3: lives loaded at reset and on game start (1–7).
- `TIME_LIMIT`, 30: seconds per life (1–63).
- `CLK_HZ`, 50_000_000: clk cycles per countdown second.
- `DEATH_HOLD`, 25_000_000: cycles spent in DYING (≥1).
- `MAX_LEVEL`, 9: saturation value of `speed`. The frog divider requires ≤9.

**Ports**
- `clk`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high; one clock; all state is loaded on the clk edge where `Reset`=1.
- `start`, in, 1: start/restart request, level-sampled.
- `frogY`, in, 10: frog Y centre from the frog block.
- `collide`, in, 1: frog overlaps a car or is in water without a log.
- `home`, in, 5: frog block `home4..home0` occupancy levels.
- `allHome`, in, 1: frog block all-homes-filled pulse.
- `frog_respawn`, out, 1: drives the frog block `Reset`.
- `gameOver`, out, 1: drives the frog block `gameOver`.
- `speed`, out, 4: level and difficulty, fed to the frog block and the lanes.
- `lives`, out, 3: remaining lives.
- `score`, out, 14: binary score, saturating at 9999.
- `time_left`, out, 6: seconds remaining for the current life.
- `state`, out, 3: FSM state encoding.

## Operation

**FSM state encodings**
- IDLE = 0
- PLAY = 1
- DYING = 2
- RESPAWN = 3
- OVER = 4

**Reset values**
- `state` = IDLE, `frog_respawn` = 1, `gameOver` = 0, `speed` = 0.
- `lives` = LIVES_INIT, `score` = 0, `time_left` = TIME_LIMIT.
- `min_y` = 428, `home_q` = 0, second counter = 0.

**IDLE**
- `frog_respawn` = 1.
- `start` = 1 → RESPAWN, with `score` = 0, `lives` = LIVES_INIT, `speed` = 0.

**RESPAWN** (exactly one cycle)
- `frog_respawn` = 1.
- Loads `time_left` = TIME_LIMIT, `min_y` = 428, second counter = 0.
- → PLAY.

**PLAY**
- `frog_respawn` = 0.
- Forward-progress scoring: `frogY` < `min_y` → `score` += 10, `min_y` ← `frogY`.
- Home entry: any bit set in `home` & ~`home_q` → `score` += 50, → RESPAWN. No life is lost. `home_q` ← `home` every cycle in all states.
- `allHome` = 1 → `score` += 1000 and `speed` ← min(`speed`+1, MAX_LEVEL). Applies in any state except IDLE and OVER.
- `collide` = 1, or timeout → DYING, with `lives` ← `lives` − 1.

**DYING**
- `frog_respawn` = 1 for DEATH_HOLD cycles.
- Then: if `lives` = 0 → OVER; otherwise → RESPAWN.

**OVER**
- `gameOver` = 1, `frog_respawn` = 1.
- `start` = 1 → IDLE with `gameOver` ← 0. The next `start` begins a new game.

**Simultaneous and boundary events**
- Same-cycle score additions are summed, then saturated at 9999.
- Home entry and `collide` in the same cycle: home wins; no life lost.
- `collide` and timeout in the same cycle: only one life is lost.
- `collide` outside PLAY: ignored.
- `lives` never underflows below 0.
- `Reset` mid-game, in any state: returns to the reset values above on the next edge.

## Timing

**Single-cycle latencies**
- Any event sampled at edge N updates `state`, `score`, `lives`, `speed`, `frog_respawn` and `gameOver` at edge N.
- Those updated values are visible during cycle N+1.

**Countdown**
- The second counter runs only in PLAY.
- It wraps at CLK_HZ−1; each wrap decrements `time_left`.
- Timeout means the counter wraps while `time_left` = 1. `time_left` becomes 0 and the FSM enters DYING on the same edge.

**State durations**
- DYING lasts exactly DEATH_HOLD cycles, counted from entry.
- RESPAWN lasts exactly 1 cycle.
- From a `collide` edge to PLAY: DEATH_HOLD+1 cycles.

**Score arithmetic**
- Computed in 15 bits, then clamped to 9999.

## Configuration

Macro: `GAME_CTRL_TIMER_EN`.
- **Defined:** countdown and timeout death operate as specified.
- **Undefined:** no second counter is synthesised, `time_left` is held at TIME_LIMIT, and timeout never occurs.

## Test plan

Bench parameters: CLK_HZ=10, DEATH_HOLD=4, TIME_LIMIT=3, LIVES_INIT=2.

1. **Reset and start.** Assert `Reset`, then pulse `start`.
   - Expected: IDLE → RESPAWN → PLAY on consecutive edges; `frog_respawn` falls entering PLAY; `lives`=2, `score`=0.
2. **Forward progress.** Step `frogY` 428→393→358, then back to 393, then 358.
   - Expected: `score`=20; no points for re-entering rows already reached.
3. **Home, then all homes.** Raise `home[2]` with `collide`=1 in the same cycle.
   - Expected: `score` += 50, RESPAWN, `lives` unchanged.
   - Then pulse `allHome` with `speed`=9.
   - Expected: `score` += 1000, `speed` stays 9.
4. **Collision to game over.** Raise `collide` in PLAY twice.
   - Expected: each time, DYING for 4 cycles, `lives` 2→1→0; after the second, OVER with `gameOver`=1.
   - Then pulse `start`.
   - Expected: IDLE, `gameOver`=0.
5. **Timeout.** With `GAME_CTRL_TIMER_EN` defined, idle in PLAY for 30 cycles.
   - Expected: `time_left` 3→2→1→0, DYING entered on the 30th edge, `lives` decremented.
   - With the macro undefined: `time_left` stays 3, no death.
6. **Saturation and mid-game reset.**
   - Preload `score`=9990 and add 50.
   - Expected: `score`=9999.
   - Assert `Reset` during DYING.
   - Expected: all reset values on the next edge.
